// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs mult/div ops as
// multi-cycle operations and exposes Busy to the hazard unit.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only
// when the macro MDU_MADD_EN is defined; otherwise codes 7..10 decode as NONE.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        RdSel,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } op_t;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic [63:0]     pending;

   op_t             op;
   logic            is_long;
   logic            start;
   logic [CW-1:0]   n_cycles;
   logic [63:0]     result;

   logic [63:0]     prod_s;
   logic [63:0]     prod_u;
   logic            div_signed;
   logic [31:0]     ua;
   logic [31:0]     ub;
   logic [31:0]     uq;
   logic [31:0]     ur;
   logic [31:0]     quot;
   logic [31:0]     rem;

   assign op = op_t'(MDUOp);

   // Signed product taken modulo 2^64 of the sign-extended operands.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // One unsigned divider serves both DIV and DIVU; signed division divides
   // magnitudes and restores signs (quotient truncates toward zero, remainder
   // follows the dividend). 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
   assign div_signed = (op == OP_DIV);
   assign ua   = (div_signed && A[31]) ? (~A + 32'd1) : A;
   assign ub   = (div_signed && B[31]) ? (~B + 32'd1) : B;
   assign uq   = (ub == '0) ? '0 : ua / ub;
   assign ur   = (ub == '0) ? '0 : ua % ub;
   assign quot = (div_signed && (A[31] ^ B[31])) ? (~uq + 32'd1) : uq;
   assign rem  = (div_signed && A[31]) ? (~ur + 32'd1) : ur;

   // Decode the presented op: is it multi-cycle, how long, and what result.
   always_comb begin
      is_long  = 1'b0;
      n_cycles = CW'(MULT_CYCLES);
      result   = {HI, LO};
      case (op)
         OP_MULT:  begin is_long = 1'b1; result = prod_s; end
         OP_MULTU: begin is_long = 1'b1; result = prod_u; end
         OP_DIV, OP_DIVU: begin
            is_long  = 1'b1;
            n_cycles = CW'(DIV_CYCLES);
            if (B != '0) result = {rem, quot};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin is_long = 1'b1; result = {HI, LO} + prod_s; end
         OP_MADDU: begin is_long = 1'b1; result = {HI, LO} + prod_u; end
         OP_MSUB:  begin is_long = 1'b1; result = {HI, LO} - prod_s; end
         OP_MSUBU: begin is_long = 1'b1; result = {HI, LO} - prod_u; end
`endif
         default: ;
      endcase
   end

   assign start  = is_long && !Req && (state == IDLE);
   assign Busy   = start | busy_q;
   assign MDUOut = RdSel ? HI : LO;

   // Control FSM: capture the result at start, count down, commit at cnt==1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_q  <= 1'b0;
         pending <= '0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  cnt     <= n_cycles;
                  busy_q  <= 1'b1;
                  pending <= result;
               end else if (!Req && op == OP_MTHI) begin
                  HI <= A;
               end else if (!Req && op == OP_MTLO) begin
                  LO <= A;
               end
            end
            RUN: begin
               if (cnt == CW'(1)) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  busy_q   <= 1'b0;
                  {HI, LO} <= pending;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu. Optional MADD checks are built when
// MDU_MADD_EN is defined; otherwise codes 7..10 are checked to decode as NONE.
module tb_mdu;

   logic        clk;
   logic        reset;
   logic        Req;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        RdSel;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   int pass_cnt = 0;
   int total_cnt = 0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Req(Req), .MDUOp(MDUOp), .A(A), .B(B),
      .RdSel(RdSel), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one op for one cycle, then NONE with scrambled operands until Busy
   // drops; returns how many sampled cycles had Busy=1 (bounded).
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, output int busy_cycles);
      @(negedge clk);
      MDUOp = op; A = a; B = b; Req = req;
      #1;
      busy_cycles = Busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         MDUOp = 4'd0; A = $urandom; B = $urandom; Req = 1'b0;
         #1;
         if (!Busy) break;
         busy_cycles++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; Req = 1'b0; MDUOp = 4'd0; A = '0; B = '0; RdSel = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({HI, LO, Busy} !== {64'd0, 1'b0})
         $display("FAIL reset_state: HI=%h LO=%h Busy=%b required HI=0 LO=0 Busy=0", HI, LO, Busy);
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int bc;
      issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, bc);
      total_cnt++;
      if (bc !== 6) $display("FAIL mult_busy: got %0d cycles required 6", bc); else pass_cnt++;
      total_cnt++;
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFE)
         $display("FAIL mult_result: HI=%h LO=%h required FFFFFFFF FFFFFFFE", HI, LO);
      else pass_cnt++;
      issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, bc);
      total_cnt++;
      if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE)
         $display("FAIL multu_result: HI=%h LO=%h required 00000001 FFFFFFFE", HI, LO);
      else pass_cnt++;
   endtask

   task automatic test_div;
      int bc;
      issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
      total_cnt++;
      if (bc !== 11) $display("FAIL div_busy: got %0d cycles required 11", bc); else pass_cnt++;
      total_cnt++;
      if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD)
         $display("FAIL div_signed: HI=%h LO=%h required FFFFFFFF FFFFFFFD", HI, LO);
      else pass_cnt++;
      issue(4'd4, 32'd7, 32'd2, 1'b0, bc);
      total_cnt++;
      if ({HI, LO} !== 64'h0000_0001_0000_0003)
         $display("FAIL divu: HI=%h LO=%h required 00000001 00000003", HI, LO);
      else pass_cnt++;
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
      total_cnt++;
      if ({HI, LO} !== 64'h0000_0000_8000_0000)
         $display("FAIL div_overflow: HI=%h LO=%h required 00000000 80000000", HI, LO);
      else pass_cnt++;
   endtask

   task automatic test_div_zero;
      int bc;
      issue(4'd5, 32'h11, 32'd0, 1'b0, bc);
      issue(4'd6, 32'h22, 32'd0, 1'b0, bc);
      issue(4'd3, 32'd1234, 32'd0, 1'b0, bc);
      total_cnt++;
      if (bc !== 11) $display("FAIL divzero_busy: got %0d cycles required 11", bc); else pass_cnt++;
      total_cnt++;
      if ({HI, LO} !== {32'h11, 32'h22})
         $display("FAIL divzero_result: HI=%h LO=%h required 00000011 00000022", HI, LO);
      else pass_cnt++;
   endtask

   task automatic test_req;
      int bc;
      issue(4'd1, 32'd3, 32'd3, 1'b1, bc);
      total_cnt++;
      if (bc !== 0 || {HI, LO} !== {32'h11, 32'h22})
         $display("FAIL req_mult: busy=%0d HI=%h LO=%h required 0 00000011 00000022", bc, HI, LO);
      else pass_cnt++;
      issue(4'd5, 32'd5, 32'd0, 1'b1, bc);
      total_cnt++;
      if (HI !== 32'h11) $display("FAIL req_mthi: HI=%h required 00000011", HI); else pass_cnt++;
      issue(4'd5, 32'd5, 32'd0, 1'b0, bc);
      RdSel = 1'b1; #1;
      total_cnt++;
      if (bc !== 0 || HI !== 32'd5 || MDUOut !== 32'd5)
         $display("FAIL mthi: busy=%0d HI=%h MDUOut=%h required 0 00000005 00000005", bc, HI, MDUOut);
      else pass_cnt++;
      RdSel = 1'b0; #1;
      total_cnt++;
      if (MDUOut !== 32'h22) $display("FAIL mduout_lo: MDUOut=%h required 00000022", MDUOut); else pass_cnt++;
   endtask

   // Ops presented during RUN are ignored; Req during RUN does not cancel.
   task automatic test_back_to_back;
      int bc;
      @(negedge clk); MDUOp = 4'd4; A = 32'd100; B = 32'd7; Req = 1'b0;
      @(negedge clk); MDUOp = 4'd6; A = 32'h123; Req = 1'b1;
      @(negedge clk); MDUOp = 4'd1; A = 32'd9; B = 32'd9; Req = 1'b0;
      @(negedge clk); MDUOp = 4'd0; Req = 1'b1;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); Req = 1'b0; #1;
         if (!Busy) break;
         bc++;
      end
      total_cnt++;
      if (bc !== 7 || {HI, LO} !== {32'd2, 32'd14})
         $display("FAIL run_ignore: tail=%0d HI=%h LO=%h required 7 00000002 0000000E", bc, HI, LO);
      else pass_cnt++;
   endtask

   task automatic test_async_reset;
      int bc;
      issue(4'd6, 32'h33, 32'd0, 1'b0, bc);
      @(negedge clk); MDUOp = 4'd3; A = 32'd100; B = 32'd3;
      @(negedge clk); MDUOp = 4'd0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1; #1;
      total_cnt++;
      if ({HI, LO, Busy} !== {64'd0, 1'b0})
         $display("FAIL reset_mid: HI=%h LO=%h Busy=%b required 0 0 0", HI, LO, Busy);
      else pass_cnt++;
      @(negedge clk); reset = 1'b0;
      repeat (15) @(negedge clk);
      total_cnt++;
      if ({HI, LO, Busy} !== {64'd0, 1'b0})
         $display("FAIL reset_late_write: HI=%h LO=%h Busy=%b required 0 0 0", HI, LO, Busy);
      else pass_cnt++;
   endtask

   task automatic test_madd;
      int bc;
      issue(4'd5, 32'd0, 32'd0, 1'b0, bc);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, bc);
`ifdef MDU_MADD_EN
      issue(4'd8, 32'd1, 32'd1, 1'b0, bc);
      total_cnt++;
      if (bc !== 6 || {HI, LO} !== 64'h0000_0001_0000_0000)
         $display("FAIL maddu: busy=%0d HI=%h LO=%h required 6 00000001 00000000", bc, HI, LO);
      else pass_cnt++;
      issue(4'd9, 32'd1, 32'd1, 1'b0, bc);
      total_cnt++;
      if ({HI, LO} !== 64'h0000_0000_FFFF_FFFF)
         $display("FAIL msub: HI=%h LO=%h required 00000000 FFFFFFFF", HI, LO);
      else pass_cnt++;
`else
      for (int op = 7; op <= 12; op++) begin
         issue(4'(op), 32'd1, 32'd1, 1'b0, bc);
         total_cnt++;
         if (bc !== 0 || {HI, LO} !== 64'h0000_0000_FFFF_FFFF)
            $display("FAIL op%0d_none: busy=%0d HI=%h LO=%h required 0 00000000 FFFFFFFF", op, bc, HI, LO);
         else pass_cnt++;
      end
`endif
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_req;
      test_back_to_back;
      test_async_reset;
      test_madd;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
